count_down_timer_mc: RTL
========================

Name: count_down_timer_mc

Overview:
Multi-channel, parametrised successor to the single-channel HMS count-down timer. NUM_CH independent BCD hh:mm:ss timers share one 1 Hz prescaler. Each channel has set/play/stop/reset commands, one-shot or auto-reload mode, and a timed ring output. One channel at a time is muxed onto the BCD display outputs.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
CLK_HZ, 5_000_000, clk cycles per 1 s tick
RING_SEC, 5, ring duration in ticks
MAX_HOUR_BCD, 8'h23, largest legal hour value
DEFAULT_BCD, 24'h000100, preset and counter value after rst ({h,m,s})
SEL_W, max(1,$clog2(NUM_CH)), width of disp_sel

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
ch_set  in  NUM_CH  load preset from *_bcd_in
ch_play  in  NUM_CH  start / resume / acknowledge
ch_stop  in  NUM_CH  pause / silence
ch_reset  in  NUM_CH  reload counter from preset and go idle
ch_reload  in  NUM_CH  level: 1 = auto-reload mode
hour_bcd_in  in  8  preset hours
minute_bcd_in  in  8  preset minutes
second_bcd_in  in  8  preset seconds
disp_sel  in  SEL_W  channel shown on outputs
hour_out_bcd  out  8  selected channel hours
minute_out_bcd  out  8  selected channel minutes
second_out_bcd  out  8  selected channel seconds
ring  out  NUM_CH  alarm active
counting  out  NUM_CH  channel in RUN
paused  out  NUM_CH  channel in PAUSE
set_err  out  1  one-cycle pulse: rejected preset
tick_1hz  out  1  one-cycle prescaler tick

Behaviour:
- rst asserted: prescaler=0; every preset and counter = DEFAULT_BCD; state IDLE; ring/counting/paused/set_err/tick_1hz = 0.
- Commands are levels. Each is registered once, then rising-edge detected. An action takes effect on the clock after the edge is detected, so outputs change 2 clk after the input rises. Holding a command high acts once only.
- Prescaler is free-running 0..CLK_HZ-1. tick_1hz = 1 for one cycle when the count equals CLK_HZ-1, then the count wraps to 0.
- States per channel: IDLE, RUN, PAUSE, RING.
- Priority within a channel: ch_reset > ch_set > ch_stop > ch_play > tick.
- ch_reset (any state): counter := preset; ring cleared; go to IDLE.
- ch_set, legal value (every nibble ≤9, min/sec ≤ 8'h59, hour ≤ MAX_HOUR_BCD): preset := input; counter := input; go to IDLE. Illegal value: set_err pulses; channel state unchanged.
- set_err is the OR over all channels.
- ch_play: IDLE/PAUSE with nonzero counter → RUN. Zero counter: ignored. In RING: ring cleared, counter := preset, go to IDLE. In RUN: no effect.
- ch_stop: RUN → PAUSE. RING → IDLE, ring cleared, counter stays 00:00:00. Otherwise no effect.
- Tick in RUN: BCD decrement.
  - Seconds ones digit borrows 0→9; seconds 00→59 borrows a minute; minutes 00→59 borrows an hour.
  - The counter never wraps below 00:00:00.
- Counter reaches 00:00:00 on a tick:
  - ring_cnt := RING_SEC; ring goes high.
  - ch_reload=0: go to RING; counting drops the same cycle.
  - ch_reload=1: counter := preset on that same tick; stay in RUN.
- ring_cnt decrements on each tick; ring falls when it reaches 0.
  - In one-shot mode, ring timeout returns the channel to IDLE with the counter held at 00:00:00.
- Outputs are registered. Display mux is combinational from registered counters. disp_sel ≥ NUM_CH shows 00:00:00.
- Channels never interact except through the shared tick.

Decomposition:
- Package cdt_pkg:
  - state enum {IDLE, RUN, PAUSE, RING}
  - hms_t: three 8-bit BCD fields
  - BCD_ZERO and BCD_59 constants
  - functions bcd_hms_dec(hms_t) and bcd_hms_valid(hms_t, max_hour)
- Sub-module cdt_channel: one channel's edge detect, FSM, preset/counter and ring counter. Instantiated NUM_CH times in a generate loop.
- The top level holds the prescaler, display mux and set_err OR.

Test Plan:
(All with CLK_HZ=10, NUM_CH=2, RING_SEC=2.)
1. Release rst, disp_sel=0 → display 00:01:00, ring=00, counting=00, tick_1hz every 10 clk.
2. Set ch0 00:00:03, play → counting[0]=1; after 3 ticks display 00:00:00, ring[0]=1 for exactly 20 clk, then IDLE.
3. Set ch0 01:00:00, play, 1 tick → 00:59:59. Stop → paused[0]=1, value held 50 clk. Play → resumes, next tick 00:59:58.
4. ch1 ch_reload=1, set 00:00:02, play → after 2 ticks ring[1]=1, counter 00:00:02, counting[1] stays 1. ch0 unchanged.
5. Set 00:60:00 → set_err one cycle, preset unchanged. Set 24:00:00 with MAX_HOUR 23 → set_err.
6. ch_stop and ch_play rise together in RUN → PAUSE. ch_reset mid-RUN → counter = preset, IDLE. rst mid-RING → all outputs at reset values immediately.

Source files
------------

// File: rtl/cdt_pkg.sv
// Shared types and BCD helpers for the multi-channel count-down timer.
//   state_t       : per-channel FSM state
//   hms_t         : packed {hour, minute, second}, each a two-digit BCD byte
//   bcd_hms_dec   : decrement an hh:mm:ss value by one second, saturating at zero
//   bcd_hms_valid : check that every nibble is a decimal digit and fields are in range
package cdt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        RING  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } hms_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_59   = 8'h59;
    localparam hms_t       HMS_ZERO = '0;

    // Two-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_byte_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic hms_t bcd_hms_dec(input hms_t t);
        hms_t r;
        r = t;
        if (t.second != BCD_ZERO) begin
            r.second = bcd_byte_dec(t.second);
        end else if (t.minute != BCD_ZERO) begin
            r.second = BCD_59;
            r.minute = bcd_byte_dec(t.minute);
        end else if (t.hour != BCD_ZERO) begin
            r.second = BCD_59;
            r.minute = BCD_59;
            r.hour   = bcd_byte_dec(t.hour);
        end
        // 00:00:00 is returned unchanged: the counter never wraps.
        return r;
    endfunction

    function automatic logic bcd_hms_valid(input hms_t t, input logic [7:0] max_hour);
        logic digits_ok;
        digits_ok = (t.hour[7:4]   <= 4'd9) && (t.hour[3:0]   <= 4'd9) &&
                    (t.minute[7:4] <= 4'd9) && (t.minute[3:0] <= 4'd9) &&
                    (t.second[7:4] <= 4'd9) && (t.second[3:0] <= 4'd9);
        // With every nibble a decimal digit, binary compare equals decimal compare.
        return digits_ok && (t.minute <= BCD_59) && (t.second <= BCD_59) &&
               (t.hour <= max_hour);
    endfunction

endpackage

// File: rtl/cdt_channel.sv
// One timer channel: command edge detection, IDLE/RUN/PAUSE/RING FSM,
// preset and BCD counter registers, and the ring-duration counter.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   tick           : one-cycle 1 Hz tick shared by all channels
//   cmd_set/play/stop/reset : command levels (rising edge acts once)
//   reload         : level, 1 = auto-reload when the counter reaches zero
//   preset_value   : candidate preset for cmd_set
//   count_value    : registered counter value
//   ring, counting, paused, set_err : registered status outputs
module cdt_channel
    import cdt_pkg::*;
#(
    parameter int          RING_SEC     = 5,
    parameter logic [7:0]  MAX_HOUR_BCD = 8'h23,
    parameter logic [23:0] DEFAULT_BCD  = 24'h000100
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic cmd_set,
    input  logic cmd_play,
    input  logic cmd_stop,
    input  logic cmd_reset,
    input  logic reload,
    input  hms_t preset_value,
    output hms_t count_value,
    output logic ring,
    output logic counting,
    output logic paused,
    output logic set_err
);

    localparam int RW = (RING_SEC < 1) ? 1 : $clog2(RING_SEC + 1);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
    localparam logic [RW-1:0] RING_ONE  = RW'(1);

    // Command bit positions, highest priority first.
    localparam int C_RESET = 3;
    localparam int C_SET   = 2;
    localparam int C_STOP  = 1;
    localparam int C_PLAY  = 0;

    logic [3:0]    cmd_d1_reg, cmd_d2_reg;
    logic [3:0]    cmd_edge;
    state_t        state_reg, state_next;
    hms_t          preset_reg, preset_next;
    hms_t          count_reg, count_next;
    hms_t          count_dec;
    logic [RW-1:0] ring_cnt_reg, ring_cnt_next;
    logic          set_err_next;
    logic          ring_reg, counting_reg, paused_reg, set_err_reg;

    assign cmd_edge  = cmd_d1_reg & ~cmd_d2_reg;
    assign count_dec = bcd_hms_dec(count_reg);

    // Only the highest-priority command edge acts in a cycle; any command
    // edge also consumes that cycle's tick for this channel.
    always_comb begin
        state_next    = state_reg;
        preset_next   = preset_reg;
        count_next    = count_reg;
        ring_cnt_next = ring_cnt_reg;
        set_err_next  = 1'b0;
        if (cmd_edge[C_RESET]) begin
            count_next    = preset_reg;
            ring_cnt_next = '0;
            state_next    = IDLE;
        end else if (cmd_edge[C_SET]) begin
            if (bcd_hms_valid(preset_value, MAX_HOUR_BCD)) begin
                preset_next   = preset_value;
                count_next    = preset_value;
                ring_cnt_next = '0;   // returning to IDLE always silences the ring
                state_next    = IDLE;
            end else begin
                set_err_next = 1'b1;
            end
        end else if (cmd_edge[C_STOP]) begin
            case (state_reg)
                RUN:  state_next = PAUSE;
                RING: begin
                    state_next    = IDLE;
                    ring_cnt_next = '0;
                end
                default: ;
            endcase
        end else if (cmd_edge[C_PLAY]) begin
            case (state_reg)
                IDLE, PAUSE: if (count_reg != HMS_ZERO) state_next = RUN;
                RING: begin
                    state_next    = IDLE;
                    ring_cnt_next = '0;
                    count_next    = preset_reg;
                end
                default: ;
            endcase
        end else if (tick) begin
            if (ring_cnt_reg != '0) begin
                ring_cnt_next = ring_cnt_reg - RING_ONE;
                if (ring_cnt_reg == RING_ONE && state_reg == RING) state_next = IDLE;
            end
            if (state_reg == RUN && count_reg != HMS_ZERO) begin
                if (count_dec == HMS_ZERO) begin
                    // Expiry restarts the ring even if a previous one is still sounding.
                    ring_cnt_next = RING_LOAD;
                    if (reload) begin
                        count_next = preset_reg;
                    end else begin
                        count_next = count_dec;
                        state_next = RING;
                    end
                end else begin
                    count_next = count_dec;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_d1_reg   <= '0;
            cmd_d2_reg   <= '0;
            state_reg    <= IDLE;
            preset_reg   <= hms_t'(DEFAULT_BCD);
            count_reg    <= hms_t'(DEFAULT_BCD);
            ring_cnt_reg <= '0;
            ring_reg     <= 1'b0;
            counting_reg <= 1'b0;
            paused_reg   <= 1'b0;
            set_err_reg  <= 1'b0;
        end else begin
            cmd_d1_reg   <= {cmd_reset, cmd_set, cmd_stop, cmd_play};
            cmd_d2_reg   <= cmd_d1_reg;
            state_reg    <= state_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            ring_cnt_reg <= ring_cnt_next;
            ring_reg     <= (ring_cnt_next != '0);
            counting_reg <= (state_next == RUN);
            paused_reg   <= (state_next == PAUSE);
            set_err_reg  <= set_err_next;
        end
    end

    assign count_value = count_reg;
    assign ring        = ring_reg;
    assign counting    = counting_reg;
    assign paused      = paused_reg;
    assign set_err     = set_err_reg;

endmodule

// File: rtl/count_down_timer_mc.sv
// Multi-channel BCD hh:mm:ss count-down timer.
// Holds the shared 1 Hz prescaler, NUM_CH cdt_channel instances, the
// display multiplexer and the set_err OR.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   ch_set/play/stop/reset/reload    : per-channel command levels
//   hour/minute/second_bcd_in        : preset value shared by all channels
//   disp_sel                         : channel shown on *_out_bcd (>= NUM_CH shows zero)
//   hour/minute/second_out_bcd       : selected channel counter
//   ring, counting, paused           : per-channel status
//   set_err                          : pulse when any channel rejects a preset
//   tick_1hz                         : one-cycle prescaler tick
module count_down_timer_mc
    import cdt_pkg::*;
#(
    parameter int          NUM_CH       = 2,
    parameter int          CLK_HZ       = 5_000_000,
    parameter int          RING_SEC     = 5,
    parameter logic [7:0]  MAX_HOUR_BCD = 8'h23,
    parameter logic [23:0] DEFAULT_BCD  = 24'h000100,
    parameter int          SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_set,
    input  logic [NUM_CH-1:0] ch_play,
    input  logic [NUM_CH-1:0] ch_stop,
    input  logic [NUM_CH-1:0] ch_reset,
    input  logic [NUM_CH-1:0] ch_reload,
    input  logic [7:0]        hour_bcd_in,
    input  logic [7:0]        minute_bcd_in,
    input  logic [7:0]        second_bcd_in,
    input  logic [SEL_W-1:0]  disp_sel,
    output logic [7:0]        hour_out_bcd,
    output logic [7:0]        minute_out_bcd,
    output logic [7:0]        second_out_bcd,
    output logic [NUM_CH-1:0] ring,
    output logic [NUM_CH-1:0] counting,
    output logic [NUM_CH-1:0] paused,
    output logic              set_err,
    output logic              tick_1hz
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0]     presc_reg, presc_next;
    logic              tick_reg;
    hms_t              preset_value;
    hms_t              count_arr [NUM_CH];
    logic [NUM_CH-1:0] set_err_vec;
    hms_t              disp;

    // tick_reg is high exactly while the prescaler holds CLK_HZ-1.
    assign presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            tick_reg  <= (presc_next == PRESC_LAST);
        end
    end

    assign tick_1hz     = tick_reg;
    assign preset_value = {hour_bcd_in, minute_bcd_in, second_bcd_in};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            cdt_channel #(
                .RING_SEC     (RING_SEC),
                .MAX_HOUR_BCD (MAX_HOUR_BCD),
                .DEFAULT_BCD  (DEFAULT_BCD)
            ) u_ch (
                .clk          (clk),
                .rst          (rst),
                .tick         (tick_reg),
                .cmd_set      (ch_set[gi]),
                .cmd_play     (ch_play[gi]),
                .cmd_stop     (ch_stop[gi]),
                .cmd_reset    (ch_reset[gi]),
                .reload       (ch_reload[gi]),
                .preset_value (preset_value),
                .count_value  (count_arr[gi]),
                .ring         (ring[gi]),
                .counting     (counting[gi]),
                .paused       (paused[gi]),
                .set_err      (set_err_vec[gi])
            );
        end
    endgenerate

    assign set_err = |set_err_vec;

    always_comb begin
        disp = HMS_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disp_sel == SEL_W'(i)) disp = count_arr[i];
        end
    end

    assign hour_out_bcd   = disp.hour;
    assign minute_out_bcd = disp.minute;
    assign second_out_bcd = disp.second;

endmodule
